// File: rtl/mmio_bus_fabric_if.sv
// Bus bundle between the core data port, the fabric and its slave peripherals.
interface mmio_bus_fabric_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic                         m_we;
  logic                         m_re;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_ready;
  logic                         m_err;
  logic [NUM_SLAVES-1:0]        s_sel;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic                         s_we;
  logic                         s_re;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_ready;
  logic                         err_valid;
  logic [ADDR_W-1:0]            err_addr;
  logic [1:0]                   err_code;
  logic                         err_clr;

  // Fabric view: it masters the slave side and answers the core.
  modport master (
    input  m_addr, m_wdata, m_we, m_re, s_rdata, s_ready, err_clr,
    output m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_we, s_re,
           err_valid, err_addr, err_code
  );

  modport slave (
    output m_addr, m_wdata, m_we, m_re, s_rdata, s_ready, err_clr,
    input  m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_we, s_re,
           err_valid, err_addr, err_code
  );
endinterface

// File: rtl/mmio_bus_fabric.sv
// Single-outstanding MMIO interconnect: base/mask decode, wait-state handshake,
// access timeout and a first-error-wins capture register.
module mmio_bus_fabric #(
  parameter int                              NUM_SLAVES     = 4,
  parameter int                              ADDR_W         = 32,
  parameter int                              DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]    SLAVE_BASE     = {32'h1000_0010, 32'h1000_0008,
                                                               32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0]    SLAVE_MASK     = {32'hFFFF_FFF8, 32'hFFFF_FFF8,
                                                               32'hFFFF_FFF8, 32'hFFFF_FF80},
  parameter int                              TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  mmio_bus_fabric_if.master bus
);
  localparam int               IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [NUM_SLAVES-1:0] sel, sel_nxt;
  logic [ADDR_W-1:0]     addr_q, addr_nxt;
  logic [DATA_W-1:0]     wdata_q, wdata_nxt;
  logic                  we_q, we_nxt, re_q, re_nxt;
  logic [DATA_W-1:0]     rdata_q, rdata_nxt;
  logic                  ready_q, ready_nxt, merr_q, merr_nxt;
  logic                  err_valid_q, err_valid_nxt;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_nxt;
  logic [1:0]            err_code_q, err_code_nxt;
  logic                  err_set;
  logic [1:0]            err_cause;
  logic [ADDR_W-1:0]     err_at;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;

  // Descending scan so the lowest matching index is the one left standing.
  function automatic logic [IDX_W:0] decode(input logic [ADDR_W-1:0] a);
    logic             found;
    logic [IDX_W-1:0] i_sel;
    found = 1'b0;
    i_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((a & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        found = 1'b1;
        i_sel = IDX_W'(i);
      end
    end
    return {found, i_sel};
  endfunction

  assign {hit, hit_idx} = decode(bus.m_addr);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sel_nxt   = sel;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    we_nxt    = we_q;
    re_nxt    = re_q;
    rdata_nxt = rdata_q;
    ready_nxt = 1'b0;
    merr_nxt  = 1'b0;
    err_set   = 1'b0;
    err_cause = 2'b00;
    err_at    = addr_q;
    case (state)
      IDLE: begin
        if (bus.m_we || bus.m_re) begin
          addr_nxt  = bus.m_addr;
          wdata_nxt = bus.m_wdata;
          err_at    = bus.m_addr;
          if ((bus.m_we && bus.m_re) || !hit) begin
            state_nxt = RESP;
            ready_nxt = 1'b1;
            merr_nxt  = 1'b1;
            rdata_nxt = '0;
            err_set   = 1'b1;
            err_cause = (bus.m_we && bus.m_re) ? 2'b11 : 2'b01;
          end else begin
            state_nxt = ACCESS;
            idx_nxt   = hit_idx;
            sel_nxt   = NUM_SLAVES'(1) << hit_idx;
            we_nxt    = bus.m_we;
            re_nxt    = bus.m_re;
            cnt_nxt   = '0;
          end
        end
      end
      ACCESS: begin
        if (bus.s_ready[idx]) begin
          state_nxt = RESP;
          ready_nxt = 1'b1;
          rdata_nxt = re_q ? bus.s_rdata[idx*DATA_W +: DATA_W] : '0;
          sel_nxt   = '0;
          we_nxt    = 1'b0;
          re_nxt    = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RESP;
          ready_nxt = 1'b1;
          merr_nxt  = 1'b1;
          rdata_nxt = '0;
          sel_nxt   = '0;
          we_nxt    = 1'b0;
          re_nxt    = 1'b0;
          err_set   = 1'b1;
          err_cause = 2'b10;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A new error beats a simultaneous clear; otherwise the first error sticks.
    err_valid_nxt = err_valid_q;
    err_addr_nxt  = err_addr_q;
    err_code_nxt  = err_code_q;
    if (err_set && (!err_valid_q || bus.err_clr)) begin
      err_valid_nxt = 1'b1;
      err_addr_nxt  = err_at;
      err_code_nxt  = err_cause;
    end else if (bus.err_clr) begin
      err_valid_nxt = 1'b0;
      err_addr_nxt  = '0;
      err_code_nxt  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sel         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      merr_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_code_q  <= 2'b00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      sel         <= sel_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      we_q        <= we_nxt;
      re_q        <= re_nxt;
      rdata_q     <= rdata_nxt;
      ready_q     <= ready_nxt;
      merr_q      <= merr_nxt;
      err_valid_q <= err_valid_nxt;
      err_addr_q  <= err_addr_nxt;
      err_code_q  <= err_code_nxt;
    end
  end

  assign bus.m_rdata   = rdata_q;
  assign bus.m_ready   = ready_q;
  assign bus.m_err     = merr_q;
  assign bus.s_sel     = sel;
  assign bus.s_addr    = addr_q;
  assign bus.s_wdata   = wdata_q;
  assign bus.s_we      = we_q;
  assign bus.s_re      = re_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Randomised self-checking bench for mmio_bus_fabric against a transaction-level model.
module tb_mmio_bus_fabric;
  localparam int NUM_SLAVES     = 4;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;
  // Slave 3 overlaps slave 0 so decode priority is exercised.
  localparam logic [127:0] BASE = {32'h0000_0010, 32'h1000_0008, 32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FF80};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmio_bus_fabric_if #(.NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mmio_bus_fabric #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] base_tab [4] = '{32'h0000_0000, 32'h1000_0000, 32'h1000_0008, 32'h0000_0010};
  logic [31:0] mask_tab [4] = '{32'hFFFF_FF80, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF0};

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rdata;
  logic        mv;
  logic [31:0] ma;
  logic [1:0]  mc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int find_slave(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mask_tab[i]) == base_tab[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] noise(input int tgt, input logic on);
    logic [3:0] n;
    n = 4'($urandom);
    if (tgt >= 0) n[tgt] = on;
    return n;
  endfunction

  task automatic model_reset();
    exp_rdata = '0;
    mv = 1'b0;
    ma = '0;
    mc = 2'b00;
  endtask

  task automatic check_err(input string tag);
    check_eq({tag, ".err_valid"}, bus.err_valid, mv);
    check_eq({tag, ".err_addr"},  bus.err_addr,  ma);
    check_eq({tag, ".err_code"},  bus.err_code,  mc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.s_ready = noise(-1, 1'b0);
      @(posedge clk); @(negedge clk);
      check_eq("idle.m_ready", bus.m_ready, 1'b0);
      check_eq("idle.s_we",    bus.s_we,    1'b0);
      check_eq("idle.s_re",    bus.s_re,    1'b0);
      check_eq("idle.m_rdata", bus.m_rdata, exp_rdata);
      check_err("idle");
    end
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.err_clr = 1'b0;
    mv = 1'b0; ma = '0; mc = 2'b00;
    check_err("clr");
  endtask

  // d = number of wait cycles before the target slave answers (>= TIMEOUT means never).
  // early = request raised while the previous response is still on the bus.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                        input logic re, input int d, input logic clr, input bit early);
    int tgt, kresp, nstrobe, seen, off, kk;
    logic [1:0]   code;
    logic [31:0]  rd;
    logic [127:0] srd;
    logic         act;
    tgt  = find_slave(addr);
    off  = early ? 1 : 0;
    seen = 0;
    srd  = {$urandom, $urandom, $urandom, $urandom};
    if (we && re)                begin code = 2'b11; kresp = 1; nstrobe = 0; end
    else if (tgt < 0)            begin code = 2'b01; kresp = 1; nstrobe = 0; end
    else if (d < TIMEOUT_CYCLES) begin code = 2'b00; kresp = d + 2; nstrobe = d + 1; end
    else begin code = 2'b10; kresp = TIMEOUT_CYCLES + 1; nstrobe = TIMEOUT_CYCLES; end
    rd = '0;
    if (code == 2'b00 && re) rd = srd[tgt*32 +: 32];

    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_we    = we;
    bus.m_re    = re;
    bus.err_clr = clr;
    bus.s_rdata = srd;
    bus.s_ready = noise((code == 2'b00 || code == 2'b10) ? tgt : -1, 1'b0);

    for (int k = 1; k <= kresp + off; k++) begin
      @(posedge clk); @(negedge clk);
      kk  = k - off;
      act = (kk >= 1) && (kk <= nstrobe);
      check_eq("s_we",    bus.s_we,    act && we);
      check_eq("s_re",    bus.s_re,    act && re);
      check_eq("m_ready", bus.m_ready, kk == kresp);
      if (act) begin
        check_eq("s_sel",   bus.s_sel,   4'(1 << tgt));
        check_eq("s_addr",  bus.s_addr,  addr);
        check_eq("s_wdata", bus.s_wdata, wdata);
        seen++;
      end else if (kk >= 1 && code != 2'b10) begin
        check_eq("s_sel.idle", bus.s_sel, 4'b0);
      end
      if (kk == kresp) begin
        exp_rdata = rd;
        if (code != 2'b00 && (!mv || clr)) begin
          mv = 1'b1; ma = addr; mc = code;
        end else if (clr) begin
          mv = 1'b0; ma = '0; mc = 2'b00;
        end
        check_eq("m_err",   bus.m_err,   code != 2'b00);
        check_eq("m_rdata", bus.m_rdata, exp_rdata);
        check_err("resp");
        bus.m_we    = 1'b0;
        bus.m_re    = 1'b0;
        bus.err_clr = 1'b0;
        bus.s_ready = '0;
      end else begin
        check_eq("m_rdata.hold", bus.m_rdata, exp_rdata);
        if (code == 2'b00 || code == 2'b10)
          bus.s_ready = noise(tgt, act && (seen == d + 1));
        else
          bus.s_ready = noise(-1, 1'b0);
      end
    end
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        w, r;
    int          sel, d;
    bit          early, prev_txn;

    reset       = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_we    = 1'b0;
    bus.m_re    = 1'b0;
    bus.err_clr = 1'b0;
    bus.s_rdata = '0;
    bus.s_ready = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.m_rdata", bus.m_rdata, 32'h0);
    check_eq("rst.m_ready", bus.m_ready, 1'b0);
    check_eq("rst.m_err",   bus.m_err,   1'b0);
    check_eq("rst.s_sel",   bus.s_sel,   4'b0);
    check_eq("rst.s_addr",  bus.s_addr,  32'h0);
    check_eq("rst.s_wdata", bus.s_wdata, 32'h0);
    check_eq("rst.s_we",    bus.s_we,    1'b0);
    check_eq("rst.s_re",    bus.s_re,    1'b0);
    check_err("rst");
    reset = 1'b1;
    idle(1);

    do_txn(32'h1000_0004, 32'h0,         1'b0, 1'b1, 0,   1'b0, 1'b0); idle(1);
    do_txn(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 3,   1'b0, 1'b0); idle(1);
    do_txn(32'h2000_0000, 32'h0,         1'b0, 1'b1, 0,   1'b0, 1'b0); idle(1);
    do_txn(32'h0000_0040, 32'h0,         1'b0, 1'b1, 100, 1'b0, 1'b0); idle(1);
    do_txn(32'h1000_0008, 32'h0,         1'b0, 1'b1, 15,  1'b0, 1'b0); idle(1);
    do_txn(32'h3000_0000, 32'h1234_5678, 1'b1, 1'b1, 0,   1'b1, 1'b0); idle(1);
    clear_err();

    prev_txn = 1'b0;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 5);
      if (sel < 4)       a = base_tab[sel] + 32'($urandom_range(0, 7));
      else if (sel == 4) a = $urandom;
      else               a = 32'h0000_0040 + 32'($urandom_range(0, 63));
      wd = $urandom;
      sel = $urandom_range(0, 9);
      w = (sel < 5);
      r = (sel == 0) || (sel >= 5);
      d = $urandom_range(0, 20);
      early = prev_txn && ($urandom_range(0, 2) == 0);
      if (!early) idle($urandom_range(1, 2));
      do_txn(a, wd, w, r, d, ($urandom_range(0, 7) == 0), early);
      prev_txn = 1'b1;
    end
    idle(1);

    // Reset in the middle of a read that would otherwise time out.
    bus.m_addr = 32'h0000_0044;
    bus.m_re   = 1'b1;
    bus.s_ready = '0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check_eq("pre_rst.s_re", bus.s_re, 1'b1);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    model_reset();
    check_eq("mid_rst.s_re",    bus.s_re,    1'b0);
    check_eq("mid_rst.s_sel",   bus.s_sel,   4'b0);
    check_eq("mid_rst.m_ready", bus.m_ready, 1'b0);
    check_eq("mid_rst.m_rdata", bus.m_rdata, 32'h0);
    check_err("mid_rst");
    bus.m_re = 1'b0;
    reset    = 1'b1;
    idle(3);
    do_txn(32'h1000_000C, 32'h0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
